// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALU operation codes and the latched instruction fields.
package mctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b111
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLT = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRL = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_INV = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ir_fields_t;

  // funct3 mapping shared by OP and OP_IMM; alt selects SUB/SRA
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_INV;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of latched opcode/funct3/funct7 into an ALU op code
// and a valid flag covering the supported RV32I subset.
module alu_ctrl_dec
  import mctrl_pkg::*;
(
  input  ir_fields_t fields_i,
  output alu_op_e    alu_ctrl_o,
  output logic       valid_o
);

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = fields_i.funct3;
  assign f7 = fields_i.funct7;

  always_comb begin
    valid_o = 1'b0;
    case (fields_i.opcode)
      OPC_LOAD:   valid_o = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OPC_STORE:  valid_o = f3 inside {3'b000, 3'b001, 3'b010};
      OPC_BRANCH: valid_o = f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
      OPC_OP:     valid_o = (f7 == F7_BASE && f3 != 3'b011) ||
                            (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      // Immediate forms: only the shifts constrain funct7
      OPC_OP_IMM: begin
        case (f3)
          3'b001:  valid_o = (f7 == F7_BASE);
          3'b101:  valid_o = (f7 == F7_BASE) || (f7 == F7_ALT);
          3'b011:  valid_o = 1'b0;
          default: valid_o = 1'b1;
        endcase
      end
      default:    valid_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl_o = ALU_INV;
    if (valid_o) begin
      case (fields_i.opcode)
        OPC_LOAD, OPC_STORE: alu_ctrl_o = ALU_ADD;
        OPC_BRANCH:          alu_ctrl_o = ALU_SUB;
        OPC_OP:              alu_ctrl_o = f3_to_op(f3, f7[5]);
        OPC_OP_IMM:          alu_ctrl_o = f3_to_op(f3, (f3 == 3'b101) && f7[5]);
        default:             alu_ctrl_o = ALU_INV;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB controller with memory wait watchdog and sticky
// trap. Define MCTRL_PERF_EN to build the retired-instruction counter.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             iReady,
  input  logic             dReady,
  input  logic             Zero,
  input  logic             Lt,
  output logic             IRWrite,
  output logic             iReq,
  output logic             ALUSrc,
  output logic [3:0]       ALUCtrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             loadPC,
  output logic             PCSrc,
  output logic [2:0]       state,
  output logic             trap,
  output logic             busErr,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_e     state_q, state_d;
  ir_fields_t fld_q, fld_d;
  logic [7:0] wait_q, wait_d, wait_inc;
  logic       trap_q, trap_d, bus_q, bus_d, ill_q, ill_d;
  alu_op_e    dec_op;
  logic       dec_valid;
  logic       is_load, is_store, is_branch, taken;

  // Register/immediate fields never reach the controller
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  alu_ctrl_dec u_dec (
    .fields_i  (fld_q),
    .alu_ctrl_o(dec_op),
    .valid_o   (dec_valid)
  );

  assign is_load   = (fld_q.opcode == OPC_LOAD);
  assign is_store  = (fld_q.opcode == OPC_STORE);
  assign is_branch = (fld_q.opcode == OPC_BRANCH);
  assign wait_inc  = wait_q + 8'd1;

  always_comb begin
    case (fld_q.funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    wait_d   = wait_q;
    trap_d   = trap_q;
    bus_d    = bus_q;
    ill_d    = ill_q;
    iReq     = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    case (state_q)
      // Fetch is held off while reset is asserted so iReq starts after release
      S_IF: if (rst) begin
        iReq = 1'b1;
        if (iReady) begin
          IRWrite      = 1'b1;
          fld_d.opcode = instr[6:0];
          fld_d.funct3 = instr[14:12];
          fld_d.funct7 = instr[31:25];
          state_d      = S_ID;
        end else if (wait_inc == LIMIT) begin
          state_d = S_TRAP;
          bus_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_ID: begin
        if (!dec_valid) begin
          state_d = S_TRAP;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_branch) begin
          loadPC  = 1'b1;
          PCSrc   = taken;
          state_d = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
        if (dReady) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            loadPC  = 1'b1;
            state_d = S_IF;
          end
        end else if (wait_inc == LIMIT) begin
          state_d = S_TRAP;
          bus_d   = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = is_load;
        loadPC   = 1'b1;
        state_d  = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
    if (state_d != state_q) wait_d = '0;
    if (state_d == S_TRAP) trap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      fld_q   <= '0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      bus_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      bus_q   <= bus_d;
      ill_q   <= ill_d;
    end
  end

  assign state   = state_q;
  assign ALUCtrl = dec_op;
  assign ALUSrc  = (state_q != S_TRAP) &&
                   (is_load || is_store || fld_q.opcode == OPC_OP_IMM);
  assign trap    = trap_q;
  assign busErr  = bus_q;
  assign illegal = ill_q;

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] ret_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ret_q <= '0;
    else if (loadPC) ret_q <= ret_q + CNT_W'(1);
  end
  assign retired = ret_q;
`else
  assign retired = '0;
`endif

endmodule
